// File: rtl/codec_i2c_arbiter.sv
// codec_i2c_arbiter: shares one codec I2C_Controller between the power-up
// register sequencer (requester 0) and runtime control (requester 1).
// Owns the control-clock divider, arbitrates, drives GO, retries NACKed or
// timed-out transfers and reports per-transfer completion status.
// Build option: define FIXED_PRIO_EN to give requester 0 absolute priority
// (no round-robin pointer); default build is round-robin.
module codec_i2c_arbiter #(
  parameter int CLK_Freq      = 50000000,
  parameter int I2C_Freq      = 20000,
  parameter int MAX_RETRY     = 3,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iREQ0,
  input  logic [23:0] iDATA0,
  output logic        oACC0,
  input  logic        iREQ1,
  input  logic [23:0] iDATA1,
  output logic        oACC1,
  output logic        oDONE,
  output logic        oDONE_ID,
  output logic        oNACK_ERR,
  output logic        oIDLE,
  output logic        oCTRL_CLK,
  output logic [23:0] oI2C_DATA,
  output logic        oI2C_GO,
  input  logic        iI2C_END,
  input  logic        iI2C_ACK
);

  localparam int DIV = CLK_Freq / I2C_Freq;
  localparam int CW  = (DIV < 1) ? 1 : $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_V   = CW'(DIV);
  localparam logic [3:0]    RETRY_V = 4'(MAX_RETRY);
  localparam logic [7:0]    TO_V    = 8'(TIMEOUT_TICKS);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_END,
    RETRY_GAP,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    retry;
  logic [7:0]    timeout;
  logic [7:0]    timeout_next;
  logic          owner;
  logic          fail;
  logic          grant_valid;
  logic          grant_id;
  logic          attempt_over;
  logic          attempt_nack;
`ifndef FIXED_PRIO_EN
  logic          rr_ptr;
`endif

  // Control-clock divider; tick marks each control-clock rising edge.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      div_cnt   <= '0;
      oCTRL_CLK <= 1'b0;
    end else if (div_cnt == DIV_V) begin
      div_cnt   <= '0;
      oCTRL_CLK <= ~oCTRL_CLK;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_V) && !oCTRL_CLK;

  // Requester selection for the next IDLE arbitration.
  always_comb begin
    grant_valid = iREQ0 | iREQ1;
`ifdef FIXED_PRIO_EN
    grant_id = ~iREQ0;
`else
    if (iREQ0 && iREQ1) grant_id = ~rr_ptr;
    else                grant_id = iREQ1;
`endif
  end

  // Attempt outcome in WAIT_END: a timeout is handled exactly like a NACK.
  always_comb begin
    timeout_next = timeout + 8'd1;
    attempt_over = iI2C_END || (timeout_next == TO_V);
    attempt_nack = iI2C_END ? iI2C_ACK : 1'b1;
  end

  // Transfer sequencer; advances only on control-clock ticks.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      oI2C_GO   <= 1'b0;
      oI2C_DATA <= '0;
      oACC0     <= 1'b0;
      oACC1     <= 1'b0;
      oDONE     <= 1'b0;
      oDONE_ID  <= 1'b0;
      oNACK_ERR <= 1'b0;
      retry     <= '0;
      timeout   <= '0;
      owner     <= 1'b0;
      fail      <= 1'b0;
`ifndef FIXED_PRIO_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      oACC0 <= 1'b0;
      oACC1 <= 1'b0;
      oDONE <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (grant_valid) begin
              oI2C_DATA <= grant_id ? iDATA1 : iDATA0;
              oACC0     <= ~grant_id;
              oACC1     <= grant_id;
              owner     <= grant_id;
`ifndef FIXED_PRIO_EN
              rr_ptr    <= grant_id;
`endif
              retry     <= '0;
              state     <= ISSUE;
            end
          end
          ISSUE: begin
            oI2C_GO <= 1'b1;
            timeout <= '0;
            state   <= WAIT_END;
          end
          WAIT_END: begin
            timeout <= timeout_next;
            if (attempt_over) begin
              oI2C_GO <= 1'b0;
              if (!attempt_nack) begin
                fail  <= 1'b0;
                state <= DONE;
              end else if (retry < RETRY_V) begin
                retry <= retry + 4'd1;
                state <= RETRY_GAP;
              end else begin
                fail  <= 1'b1;
                state <= DONE;
              end
            end
          end
          RETRY_GAP: begin
            state <= ISSUE;
          end
          DONE: begin
            oDONE     <= 1'b1;
            oDONE_ID  <= owner;
            oNACK_ERR <= fail;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign oIDLE = (state == IDLE);

endmodule

// File: tb/tb_codec_i2c_arbiter.sv
// Directed bench for codec_i2c_arbiter. DIV=10, tick period 22 iCLK.
// Instance 0 (default timeout) talks to a controller model that answers on
// the 8th tick of GO; instance 1 (TIMEOUT_TICKS=5) never sees END.
module tb_codec_i2c_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req0, req1;
  logic [23:0] data0 [2];
  logic [23:0] data1 [2];
  logic [1:0]  acc0_w, acc1_w, done_w, did_w, err_w, idle_w, ctl_w, go_w;
  logic [23:0] data_w [2];
  logic        end_a, ack_a;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  codec_i2c_arbiter #(.CLK_Freq(1000), .I2C_Freq(100), .MAX_RETRY(3),
                      .TIMEOUT_TICKS(255)) dut (
    .iCLK(clk), .iRST_N(rst_n),
    .iREQ0(req0[0]), .iDATA0(data0[0]), .oACC0(acc0_w[0]),
    .iREQ1(req1[0]), .iDATA1(data1[0]), .oACC1(acc1_w[0]),
    .oDONE(done_w[0]), .oDONE_ID(did_w[0]), .oNACK_ERR(err_w[0]),
    .oIDLE(idle_w[0]), .oCTRL_CLK(ctl_w[0]), .oI2C_DATA(data_w[0]),
    .oI2C_GO(go_w[0]), .iI2C_END(end_a), .iI2C_ACK(ack_a));

  codec_i2c_arbiter #(.CLK_Freq(1000), .I2C_Freq(100), .MAX_RETRY(3),
                      .TIMEOUT_TICKS(5)) dut_to (
    .iCLK(clk), .iRST_N(rst_n),
    .iREQ0(req0[1]), .iDATA0(data0[1]), .oACC0(acc0_w[1]),
    .iREQ1(req1[1]), .iDATA1(data1[1]), .oACC1(acc1_w[1]),
    .oDONE(done_w[1]), .oDONE_ID(did_w[1]), .oNACK_ERR(err_w[1]),
    .oIDLE(idle_w[1]), .oCTRL_CLK(ctl_w[1]), .oI2C_DATA(data_w[1]),
    .oI2C_GO(go_w[1]), .iI2C_END(1'b0), .iI2C_ACK(1'b0));

  // observation state
  int ticks, cyc, acc_tick, gr_n, dn_n, min_gap, last_fall;
  int rises[2], goticks[2], done_n[2], accn[2], last_id[2], last_err[2];
  int gr[8];
  logic [23:0] done_dat[8];
  logic [1:0] go_prev = '0;
  int attempt, nack_count, mcnt;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    ticks = 0; acc_tick = -1; gr_n = 0; dn_n = 0;
    min_gap = 1000000; last_fall = -1;
    for (int i = 0; i < 2; i++) begin
      rises[i] = 0; goticks[i] = 0; done_n[i] = 0; accn[i] = 0;
      last_id[i] = -1; last_err[i] = -1;
    end
  endtask

  task automatic wait_acc(input int idx, input int want, input int budget);
    int n = 0;
    while (accn[idx] < want && n < budget) begin @(negedge clk); n++; end
    if (accn[idx] < want) check("acc_wait_expired", accn[idx], want);
  endtask

  task automatic wait_done(input int idx, input int want, input int budget);
    int n = 0;
    while (done_n[idx] < want && n < budget) begin @(negedge clk); n++; end
    if (done_n[idx] < want) check("done_wait_expired", done_n[idx], want);
  endtask

  // Controller model for instance 0 plus per-tick GO accounting.
  always @(posedge ctl_w[0]) begin
    #1;
    ticks++;
    for (int i = 0; i < 2; i++) if (go_w[i]) goticks[i]++;
    if (go_w[0]) begin
      mcnt++;
      if (mcnt == 8) begin
        end_a = 1'b1;
        ack_a = (attempt < nack_count);
        attempt++;
      end
    end else begin
      mcnt  = 0;
      end_a = 1'b0;
      ack_a = 1'b0;
    end
  end

  // Pulse and edge monitor, sampled away from the active edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (acc0_w[i] || acc1_w[i]) begin
        accn[i]++;
        if (i == 0) begin
          if (acc_tick < 0) acc_tick = ticks;
          if (gr_n < 8) begin gr[gr_n] = acc1_w[i] ? 1 : 0; gr_n++; end
        end
      end
      if (done_w[i]) begin
        done_n[i]++;
        last_id[i]  = int'(did_w[i]);
        last_err[i] = int'(err_w[i]);
        if (i == 0 && dn_n < 8) begin done_dat[dn_n] = data_w[0]; dn_n++; end
      end
      if (go_w[i] && !go_prev[i]) begin
        rises[i]++;
        if (i == 0 && last_fall >= 0 && (cyc - last_fall) < min_gap)
          min_gap = cyc - last_fall;
      end
      if (!go_w[i] && go_prev[i] && i == 0) last_fall = cyc;
      go_prev[i] = go_w[i];
    end
  end

  initial begin
    int exp_id;
    cyc = 0; attempt = 0; nack_count = 0; mcnt = 0;
    end_a = 1'b0; ack_a = 1'b0;
    rst_n = 1'b0; req0 = '0; req1 = '0;
    data0[0] = '0; data1[0] = '0; data0[1] = '0; data1[1] = '0;
    clear_stats();
    #23;
    check("rst_go",   int'(go_w[0]), 0);
    check("rst_ctl",  int'(ctl_w[0]), 0);
    check("rst_idle", int'(idle_w[0]), 1);
    check("rst_data", int'(data_w[0]), 0);
    check("rst_done", int'(done_w[0]), 0);

    // single request, ACK on 8th tick
    req0[0] = 1'b1; data0[0] = 24'h340C00;
    @(negedge clk); rst_n = 1'b1; clear_stats();
    wait_acc(0, 1, 600);
    req0[0] = 1'b0;
    wait_done(0, 1, 2000);
    check("single_acc_tick", acc_tick, 1);
    check("single_grant",    gr[0], 0);
    check("single_go_rises", rises[0], 1);
    check("single_go_ticks", goticks[0], 8);
    check("single_done_n",   done_n[0], 1);
    check("single_id",       last_id[0], 0);
    check("single_err",      last_err[0], 0);
    check("single_data",     int'(data_w[0]), 24'h340C00);
    check("single_idle",     int'(idle_w[0]), 1);

    // contention, both held
    clear_stats();
    data0[0] = 24'h112233; data1[0] = 24'h445566;
    req0[0] = 1'b1; req1[0] = 1'b1;
    wait_acc(0, 4, 8000);
    req0[0] = 1'b0; req1[0] = 1'b0;
    wait_done(0, 4, 3000);
    for (int k = 0; k < 4; k++) begin
`ifdef FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = (k % 2 == 0) ? 1 : 0;
`endif
      check($sformatf("cont_grant%0d", k), gr[k], exp_id);
      check($sformatf("cont_data%0d", k), int'(done_dat[k]),
            exp_id == 1 ? 24'h445566 : 24'h112233);
    end

    // two NACKs then ACK
    clear_stats(); attempt = 0; nack_count = 2;
    data0[0] = 24'h55AA01; req0[0] = 1'b1;
    wait_acc(0, 1, 600);
    req0[0] = 1'b0;
    wait_done(0, 1, 4000);
    check("retry_go_rises", rises[0], 3);
    check("retry_go_ticks", goticks[0], 24);
    check("retry_gap_ok",   int'(min_gap >= 22), 1);
    check("retry_err",      last_err[0], 0);

    // persistent NACK
    clear_stats(); attempt = 0; nack_count = 100;
    data0[0] = 24'h55AA02; req0[0] = 1'b1;
    wait_acc(0, 1, 600);
    req0[0] = 1'b0;
    wait_done(0, 1, 5000);
    check("pnack_go_rises", rises[0], 4);
    check("pnack_done_n",   done_n[0], 1);
    check("pnack_err",      last_err[0], 1);
    check("pnack_idle",     int'(idle_w[0]), 1);

    // timeout on instance 1
    clear_stats();
    data0[1] = 24'h0F0F0F; req0[1] = 1'b1;
    wait_acc(1, 1, 600);
    req0[1] = 1'b0;
    wait_done(1, 1, 4000);
    check("to_go_rises", rises[1], 4);
    check("to_go_ticks", goticks[1], 20);
    check("to_err",      last_err[1], 1);
    check("to_id",       last_id[1], 0);

    // reset while waiting for END
    clear_stats(); attempt = 0; nack_count = 0;
    data0[0] = 24'h778899; req0[0] = 1'b1;
    wait_acc(0, 1, 600);
    req0[0] = 1'b0;
    begin
      int n = 0;
      while (goticks[0] < 3 && n < 1000) begin @(negedge clk); n++; end
    end
    check("mid_go_before", int'(go_w[0]), 1);
    rst_n = 1'b0;
    #1;
    check("mid_go",   int'(go_w[0]), 0);
    check("mid_ctl",  int'(ctl_w[0]), 0);
    check("mid_idle", int'(idle_w[0]), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    repeat (660) @(negedge clk);
    check("mid_no_done", done_n[0], 0);
    data0[0] = 24'h1A2B3C; req0[0] = 1'b1;
    wait_acc(0, 1, 600);
    req0[0] = 1'b0;
    wait_done(0, 1, 2000);
    check("post_done_n", done_n[0], 1);
    check("post_err",    last_err[0], 0);
    check("post_data",   int'(data_w[0]), 24'h1A2B3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/codec_i2c_arbiter.md
Name: codec_i2c_arbiter

Overview:
Shares the single codec I2C_Controller (GO/END/ACK, 24-bit {slave,sub,data} word) between two requesters: requester 0 is the power-up register sequencer, requester 1 is runtime control (volume, mute, input select). The block owns the I2C control clock divider, arbitrates between the requesters and drives GO. It retries NACKed or timed-out transfers and returns a per-transfer completion status.

Parameters:
CLK_Freq, 50000000, iCLK frequency in Hz
I2C_Freq, 20000, control clock toggle rate; DIV = CLK_Freq/I2C_Freq
MAX_RETRY, 3, retries after the first attempt before reporting an error (0..15)
TIMEOUT_TICKS, 255, ticks in WAIT_END without iI2C_END before the attempt counts as failed (1..255)

Ports:
iCLK  in  1  system clock
iRST_N  in  1  reset
iREQ0  in  1  requester 0 has a word pending (level)
iDATA0  in  24  requester 0 word {slave,sub,data}
oACC0  out  1  one-iCLK pulse: word 0 latched, requester may drop or change iREQ0/iDATA0
iREQ1  in  1  requester 1 pending
iDATA1  in  24  requester 1 word
oACC1  out  1  one-iCLK pulse: word 1 latched
oDONE  out  1  one-iCLK pulse: transfer finished
oDONE_ID  out  1  requester that owned the finished transfer; valid with oDONE
oNACK_ERR  out  1  with oDONE: 1 = all attempts failed
oIDLE  out  1  high in IDLE
oCTRL_CLK  out  1  I2C_Controller work clock
oI2C_DATA  out  24  word to controller
oI2C_GO  out  1  start transfer
iI2C_END  in  1  controller end of transfer
iI2C_ACK  in  1  controller ack status, 1 = slave NACK

Behaviour:
- Reset iRST_N, asynchronous, active-low; clock iCLK. All logic is in the iCLK domain.
- Reset values: oCTRL_CLK=0, divider=0, oI2C_GO=0, oI2C_DATA=0, oACC0/1=0, oDONE=0, oDONE_ID=0, oNACK_ERR=0, state IDLE (oIDLE=1), round-robin pointer=0, retry=0, timeout=0.
- Divider: the counter runs 0..DIV. At DIV it wraps to 0 and oCTRL_CLK toggles. tick = wrap while oCTRL_CLK=0, which marks a control-clock rising edge. Tick period = 2*(DIV+1) iCLK cycles.
- The FSM advances only on tick cycles. iI2C_END and iI2C_ACK are sampled only on ticks.
- IDLE: on tick with any iREQ high, grant one requester.
  - Round-robin: if both are requesting, grant the requester not equal to the pointer's last grant. The pointer updates on grant.
  - Latch the granted iDATA into oI2C_DATA, pulse the matching oACC in the same iCLK cycle, clear retry, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (tick): oI2C_GO<=1, timeout<=0, go to WAIT_END.
- WAIT_END (tick):
  - If iI2C_END=1: oI2C_GO<=0.
    - iI2C_ACK=0: success, go to DONE.
    - iI2C_ACK=1 and retry<MAX_RETRY: retry++, go to RETRY_GAP.
    - Otherwise: fail, go to DONE.
  - Else timeout++. On reaching TIMEOUT_TICKS: oI2C_GO<=0 and treat the attempt exactly as a NACK (same retry/fail rule).
- RETRY_GAP (tick): GO stays 0 for one full tick so the controller rearms, then go to ISSUE. oI2C_DATA is unchanged.
- DONE (tick): pulse oDONE with oDONE_ID and oNACK_ERR for exactly that iCLK cycle, then go to IDLE. GO is therefore low for at least one tick between transfers.
- oI2C_DATA holds its value from grant until the next grant.
- A requester dropping iREQ before its oACC pulse is simply not served. After oACC, iREQ/iDATA are ignored until the next IDLE arbitration.
- Reset mid-transfer returns every register to its reset value immediately, with GO=0. A pending controller transfer is abandoned.

Optional Feature:
FIXED_PRIO_EN: when defined, requester 0 always wins simultaneous requests and the round-robin pointer is removed. This guarantees the power-up sequence completes before any runtime write. When undefined, round-robin as above.

Test Plan:
- Bench setup: CLK_Freq=1000, I2C_Freq=100, so DIV=10 and the tick period is 22 iCLK.
- Single request: iREQ0, iDATA0=24'h34_0C00 with the controller model answering END=1/ACK=0 on the 8th tick → oACC0 on the first tick; GO high for 8 ticks; one oDONE with ID=0, ERR=0; oI2C_DATA=0x340C00.
- Contention (round-robin build): iREQ0 and iREQ1 asserted together and held → grants alternate 1,0,1,0 (pointer reset 0). With FIXED_PRIO_EN → all four grants go to 0 while iREQ0 stays high.
- NACK retry: model returns ACK=1 twice, then 0; MAX_RETRY=3 → GO pulses 3 times, each separated by ≥1 tick low; oDONE ERR=0.
- Persistent NACK: ACK=1 always → 4 attempts (1+MAX_RETRY), then oDONE ERR=1, then IDLE.
- Timeout: END never asserted, TIMEOUT_TICKS=5 → GO drops after 5 ticks in WAIT_END; 4 attempts; oDONE ERR=1.
- Reset mid-transfer: iRST_N low in WAIT_END → GO=0, oCTRL_CLK=0, oIDLE=1 in the same cycle; no oDONE. After release, a new request is served normally.
